// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter in front of a register-file write port.
// Writes to the hardwired-zero register are accepted but dropped, and both drops and address collisions are counted.
module regfile_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [4:0]        req0_addr,
    input  logic [4:0]        req1_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              flush,
    output logic              wr_en,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        coll_cnt
);
    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic              rr_q, rr_d;
    logic              wr_en_q, wr_en_d;
    logic [4:0]        wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [7:0]        drop_q, drop_d;
    logic [7:0]        coll_q, coll_d;

    logic              gnt0, gnt1, hs, coll;
    logic [4:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Grants depend only on valids, flush and the pointer; rst_n gating keeps readies low during reset.
    always_comb begin
        gnt0 = rst_n && !flush && req0_valid && (!req1_valid || !rr_q);
        gnt1 = rst_n && !flush && req1_valid && (!req0_valid ||  rr_q);
    end

    always_comb begin
        hs       = gnt0 || gnt1;
        sel_addr = gnt1 ? req1_addr : req0_addr;
        sel_data = gnt1 ? req1_data : req0_data;
        coll     = !flush && req0_valid && req1_valid && (req0_addr == req1_addr);
        rr_d     = hs ? gnt0 : rr_q;
        wr_en_d  = hs && (sel_addr != ZR);
        drop_d   = drop_q;
        coll_d   = coll_q;
        if (hs && (sel_addr == ZR) && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;
        if (coll && (coll_q != 8'hFF))
            coll_d = coll_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            drop_q    <= '0;
            coll_q    <= '0;
        end else begin
            rr_q    <= rr_d;
            wr_en_q <= wr_en_d;
            drop_q  <= drop_d;
            coll_q  <= coll_d;
            // Address and data only move on a real write; idle and dropped cycles leave them as they were.
            if (wr_en_d) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign drop_cnt   = drop_q;
    assign coll_cnt   = coll_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          v0 = 0, v1 = 0, fl = 0;
    logic          r0, r1;
    logic [4:0]    a0 = 0, a1 = 0;
    logic [DW-1:0] d0 = 0, d1 = 0;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    drop_cnt, coll_cnt;

    int errors = 0;
    int checks = 0;

    // model state
    int            m_ptr, m_drop, m_coll;
    logic          m_wr_en;
    logic [4:0]    m_addr;
    logic [DW-1:0] m_data;
    logic          obs_r0, obs_r1, exp_r0, exp_r1;

    regfile_write_arbiter #(.DATA_W(DW), .ZERO_REG(31)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req1_valid(v1),
        .req0_ready(r0), .req1_ready(r1),
        .req0_addr(a0), .req1_addr(a1),
        .req0_data(d0), .req1_data(d1),
        .flush(fl),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .drop_cnt(drop_cnt), .coll_cnt(coll_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ptr = 0; m_drop = 0; m_coll = 0;
        m_wr_en = 0; m_addr = '0; m_data = '0;
    endtask

    // One cycle of the arbitration rules, computed from the current inputs.
    task automatic model_step(output logic e0, output logic e1);
        int w;
        logic [4:0] a;
        w = -1;
        if (!fl) begin
            if (v0 && v1) w = m_ptr;
            else if (v0) w = 0;
            else if (v1) w = 1;
            if (v0 && v1 && a0 == a1 && m_coll < 255) m_coll++;
        end
        e0 = (w == 0);
        e1 = (w == 1);
        m_wr_en = 0;
        if (w >= 0) begin
            m_ptr = 1 - w;
            a = (w == 1) ? a1 : a0;
            if (a == 5'd31) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_wr_en = 1;
                m_addr  = a;
                m_data  = (w == 1) ? d1 : d0;
            end
        end
    endtask

    // Called at posedge+1: sample readies mid-cycle, advance the model, return at next posedge+1.
    task automatic tick();
        #3;
        obs_r0 = r0;
        obs_r1 = r1;
        model_step(exp_r0, exp_r1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic nv0, input logic nv1, input logic nf,
                         input logic [4:0] na0, input logic [4:0] na1,
                         input logic [DW-1:0] nd0, input logic [DW-1:0] nd1);
        v0 = nv0; v1 = nv1; fl = nf; a0 = na0; a1 = na1; d0 = nd0; d1 = nd1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 0, 5'd3, 5'd4, 64'h1, 64'h2);
        model_reset();
        #2;
        checks++; if (r0 !== 1'b0 || r1 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b want=00", r0, r1); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
        checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got=%0d want=0", wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got=%h want=0", wr_data); end
        checks++; if (drop_cnt !== 8'd0 || coll_cnt !== 8'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d want=0/0", drop_cnt, coll_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_single();
        drive(1, 0, 0, 5'd5, 5'd0, 64'hA5, 64'h0);
        tick();
        checks++; if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin errors++; $display("FAIL single_ready got=%b%b want=10", obs_r0, obs_r1); end
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'hA5)
            begin errors++; $display("FAIL single_write got=%b/%0d/%h want=1/5/a5", wr_en, wr_addr, wr_data); end
        drive(0, 0, 0, 5'd5, 5'd0, 64'hA5, 64'h0);
        tick();
        checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 64'hA5)
            begin errors++; $display("FAIL idle_hold got=%b/%0d/%h want=0/5/a5", wr_en, wr_addr, wr_data); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_a [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 5'd1, 5'd2, 64'(100 + i), 64'(200 + i));
            tick();
            checks++; if (obs_r0 !== (i % 2 == 0) || obs_r1 !== (i % 2 == 1))
                begin errors++; $display("FAIL rr_grant[%0d] got=%b%b want_req=%0d", i, obs_r0, obs_r1, i % 2); end
            checks++; if (wr_en !== 1'b1 || wr_addr !== exp_a[i])
                begin errors++; $display("FAIL rr_write[%0d] got=%b/%0d want=1/%0d", i, wr_en, wr_addr, exp_a[i]); end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_drop();
        do_reset();
        drive(0, 1, 0, 5'd0, 5'd31, 64'h0, 64'hDEAD);
        tick();
        checks++; if (obs_r1 !== 1'b1) begin errors++; $display("FAIL drop_ready got=%b want=1", obs_r1); end
        checks++; if (wr_en !== 1'b0 || drop_cnt !== 8'd1)
            begin errors++; $display("FAIL drop_first got=%b/%0d want=0/1", wr_en, drop_cnt); end
        for (int i = 1; i < 300; i++) tick();
        checks++; if (drop_cnt !== 8'd255 || drop_cnt !== 8'(m_drop))
            begin errors++; $display("FAIL drop_saturate got=%0d want=255", drop_cnt); end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_collision();
        do_reset();
        drive(1, 1, 0, 5'd7, 5'd7, 64'h70, 64'h71);
        tick();
        checks++; if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin errors++; $display("FAIL coll_grant got=%b%b want=10", obs_r0, obs_r1); end
        checks++; if (coll_cnt !== 8'd1 || wr_en !== 1'b1 || wr_data !== 64'h70)
            begin errors++; $display("FAIL coll_first got=%0d/%b/%h want=1/1/70", coll_cnt, wr_en, wr_data); end
        drive(0, 1, 0, 5'd7, 5'd7, 64'h70, 64'h71);
        tick();
        checks++; if (obs_r1 !== 1'b1) begin errors++; $display("FAIL coll_loser got=%b want=1", obs_r1); end
        checks++; if (coll_cnt !== 8'd1 || wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 64'h71)
            begin errors++; $display("FAIL coll_second got=%0d/%b/%0d/%h want=1/1/7/71", coll_cnt, wr_en, wr_addr, wr_data); end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 5'd3, 5'd4, 64'h33, 64'h44);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 5'd3, 5'd4, 64'h33, 64'h44);
            tick();
            checks++; if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0 || wr_en !== 1'b0)
                begin errors++; $display("FAIL flush[%0d] got=%b%b/%b want=00/0", i, obs_r0, obs_r1, wr_en); end
        end
        drive(1, 1, 0, 5'd3, 5'd4, 64'h33, 64'h44);
        tick();
        checks++; if (obs_r1 !== 1'b1 || obs_r0 !== 1'b0 || wr_addr !== 5'd4)
            begin errors++; $display("FAIL flush_resume got=%b%b/%0d want=01/4", obs_r0, obs_r1, wr_addr); end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 5'd9, 5'd0, 64'h99, 64'h0);
        tick();
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b want=1", wr_en); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== '0 || r0 !== 1'b0)
            begin errors++; $display("FAIL areset_now got=%b/%0d/%h/%b want=0/0/0/0", wr_en, wr_addr, wr_data, r0); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 1, 0, 5'd9, 5'd10, 64'h99, 64'hAA);
        tick();
        checks++; if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin errors++; $display("FAIL areset_rearb got=%b%b want=10", obs_r0, obs_r1); end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        logic [4:0] pool [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!v0 && $urandom_range(0, 2) != 0) begin
                v0 = 1; a0 = pool[$urandom_range(0, 4)]; d0 = {$urandom, $urandom};
            end
            if (!v1 && $urandom_range(0, 2) != 0) begin
                v1 = 1; a1 = pool[$urandom_range(0, 4)]; d1 = {$urandom, $urandom};
            end
            fl = ($urandom_range(0, 7) == 0);
            tick();
            checks++; if (obs_r0 !== exp_r0 || obs_r1 !== exp_r1)
                begin errors++; $display("FAIL rand_grant[%0d] got=%b%b want=%b%b", c, obs_r0, obs_r1, exp_r0, exp_r1); end
            checks++; if (wr_en !== m_wr_en || wr_addr !== m_addr || wr_data !== m_data)
                begin errors++; $display("FAIL rand_write[%0d] got=%b/%0d/%h want=%b/%0d/%h", c, wr_en, wr_addr, wr_data, m_wr_en, m_addr, m_data); end
            checks++; if (drop_cnt !== 8'(m_drop) || coll_cnt !== 8'(m_coll))
                begin errors++; $display("FAIL rand_cnt[%0d] got=%0d/%0d want=%0d/%0d", c, drop_cnt, coll_cnt, m_drop, m_coll); end
            if (obs_r0) v0 = 0;
            if (obs_r1) v1 = 0;
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_collision();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
